// File: rtl/boreal_pkg.sv
// rtl/boreal_pkg.sv - state encoding, defaults and winner selection for boreal_sram_arb
package boreal_pkg;

    localparam int SRAM_AW_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Returns 1 when the DMA port wins; only meaningful with at least one sel high.
    function automatic logic pick_dma(
        input logic cpu_sel,
        input logic dma_sel,
        input logic prio_mode,
        input logic starved,
        input logic last_dma
    );
        if (!(cpu_sel && dma_sel)) return dma_sel;
        if (prio_mode) return !starved;
        return !last_dma;
    endfunction

endpackage

// File: rtl/boreal_sram_arb.sv
// rtl/boreal_sram_arb.sv - two-port (CPU/DMA) single-SRAM arbiter, one access per three cycles
module boreal_sram_arb
    import boreal_pkg::*;
#(
    parameter int SRAM_AW    = SRAM_AW_DEF,
    parameter int DMA_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_sel,
    input  logic               cpu_wr,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ack,
    input  logic               dma_sel,
    input  logic               dma_wr,
    input  logic [SRAM_AW-1:0] dma_addr,
    input  logic [31:0]        dma_wdata,
    output logic [31:0]        dma_rdata,
    output logic               dma_ack,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    input  logic               stat_clr,
    output logic [15:0]        conflict_cnt
);

    localparam logic PRIO_MODE = (DMA_PRIO != 0);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_t         state_q, state_d;
    logic               en_q, en_d;
    logic               we_q, we_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               cack_q, cack_d;
    logic               dack_q, dack_d;
    logic               grant_dma_q, grant_dma_d;
    logic               last_dma_q, last_dma_d;
    logic [2:0]         starve_q, starve_d;
    logic [15:0]        conflict_q, conflict_d;
    logic               tie;
    logic               win_dma;

    assign tie     = cpu_sel && dma_sel;
    assign win_dma = pick_dma(cpu_sel, dma_sel, PRIO_MODE, starve_q == STARVE_LIM, last_dma_q);

    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cack_d      = 1'b0;
        dack_d      = 1'b0;
        grant_dma_d = grant_dma_q;
        last_dma_d  = last_dma_q;
        starve_d    = starve_q;
        conflict_d  = conflict_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_sel || dma_sel) begin
                    grant_dma_d = win_dma;
                    last_dma_d  = win_dma;
                    en_d        = 1'b1;
                    we_d        = win_dma ? dma_wr    : cpu_wr;
                    addr_d      = win_dma ? dma_addr  : cpu_addr;
                    wdata_d     = win_dma ? dma_wdata : cpu_wdata;
                    if (!win_dma)
                        starve_d = 3'd0;
                    else if (tie)
                        starve_d = starve_q + 3'd1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cack_d  = !grant_dma_q;
                dack_d  = grant_dma_q;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Clear beats a same-cycle tie increment.
        if (stat_clr)
            conflict_d = 16'h0000;
        else if (state_q == ST_IDLE && tie && conflict_q != 16'hFFFF)
            conflict_d = conflict_q + 16'h0001;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            cack_q      <= 1'b0;
            dack_q      <= 1'b0;
            grant_dma_q <= 1'b0;
            last_dma_q  <= 1'b1;
            starve_q    <= 3'd0;
            conflict_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cack_q      <= cack_d;
            dack_q      <= dack_d;
            grant_dma_q <= grant_dma_d;
            last_dma_q  <= last_dma_d;
            starve_q    <= starve_d;
            conflict_q  <= conflict_d;
        end
    end

    assign sram_en      = en_q;
    assign sram_we      = we_q;
    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;
    assign cpu_ack      = cack_q;
    assign dma_ack      = dack_q;
    // Read data is only steered to the port holding the ack; everyone else sees zero.
    assign cpu_rdata    = cack_q ? sram_rdata : 32'h0;
    assign dma_rdata    = dack_q ? sram_rdata : 32'h0;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_boreal_sram_arb.sv
// tb/tb_boreal_sram_arb.sv - self-checking bench for boreal_sram_arb (round-robin and DMA-priority instances)
module tb_boreal_sram_arb;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          cpu_sel = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = 32'h0;
    logic          dma_sel = 1'b0, dma_wr = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [31:0]   dma_wdata = 32'h0;
    logic          stat_clr = 1'b0;

    // index 0: round-robin instance, index 1: DMA-priority instance
    logic [31:0]   cpu_rdata [2];
    logic [31:0]   dma_rdata [2];
    logic          cpu_ack [2];
    logic          dma_ack [2];
    logic          sram_en [2];
    logic          sram_we [2];
    logic [AW-1:0] sram_addr [2];
    logic [31:0]   sram_wdata [2];
    logic [31:0]   sram_rdata [2];
    logic [15:0]   conflict_cnt [2];

    boreal_sram_arb #(.SRAM_AW(AW), .DMA_PRIO(0), .STARVE_MAX(4)) u_rr (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .dma_sel(dma_sel), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata[0]), .dma_ack(dma_ack[0]),
        .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
        .stat_clr(stat_clr), .conflict_cnt(conflict_cnt[0])
    );

    boreal_sram_arb #(.SRAM_AW(AW), .DMA_PRIO(1), .STARVE_MAX(4)) u_prio (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .dma_sel(dma_sel), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata[1]), .dma_ack(dma_ack[1]),
        .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
        .stat_clr(stat_clr), .conflict_cnt(conflict_cnt[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        return {22'h0, a} ^ 32'hA5A5_0000;
    endfunction

    // SRAM macros: one word of read latency after the strobe cycle.
    bit [31:0] mem [2][1024];
    bit        wrt [2][1024];
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (sram_en[m]) begin
                if (sram_we[m]) begin
                    mem[m][sram_addr[m]] <= sram_wdata[m];
                    wrt[m][sram_addr[m]] <= 1'b1;
                end
                sram_rdata[m] <= wrt[m][sram_addr[m]] ? mem[m][sram_addr[m]] : pat(sram_addr[m]);
            end
        end
    end

    // Reference model: a grant at edge g puts the strobe out after g and the ack out after g+1;
    // the port is free to arbitrate again at edge g+3.
    int            k = 0;
    int            gedge [2];
    bit            gdma [2];
    bit            gwr [2];
    int            losses [2];
    bit            last_dma [2];
    logic [15:0]   mcnt [2];
    bit [31:0]     gmem [2][1024];
    bit            gwrt [2][1024];
    logic [31:0]   exp_rd [2];
    logic          e_en [2], e_we [2], e_cack [2], e_dack [2], e_rdchk [2];
    logic [AW-1:0] e_addr [2];
    logic [31:0]   e_wdata [2];
    bit            preload_req = 1'b0;
    bit            cnt_forced = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit md;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                gedge[m] = -100; losses[m] = 0; last_dma[m] = 1'b1; mcnt[m] = 16'h0;
                e_en[m] = 0; e_we[m] = 0; e_cack[m] = 0; e_dack[m] = 0; e_rdchk[m] = 0;
                e_addr[m] = '0; e_wdata[m] = 32'h0;
            end
        end else begin
            k++;
            for (int m = 0; m < 2; m++) begin
                e_en[m] = 0; e_we[m] = 0; e_cack[m] = 0; e_dack[m] = 0; e_rdchk[m] = 0;
                if (k == gedge[m] + 1) begin
                    if (gdma[m]) e_dack[m] = 1; else e_cack[m] = 1;
                    e_rdchk[m] = !gwr[m];
                end
                if (preload_req)
                    mcnt[m] = 16'hFFFE;
                else if (stat_clr)
                    mcnt[m] = 16'h0;
                else if (k > gedge[m] + 2 && cpu_sel && dma_sel && mcnt[m] != 16'hFFFF)
                    mcnt[m] = mcnt[m] + 16'h1;
                if (k > gedge[m] + 2 && (cpu_sel || dma_sel)) begin
                    if (cpu_sel && dma_sel)
                        md = (m == 1) ? (losses[m] != 4) : !last_dma[m];
                    else
                        md = dma_sel;
                    if (md && cpu_sel) losses[m]++;
                    if (!md) losses[m] = 0;
                    last_dma[m] = md;
                    gedge[m] = k;
                    gdma[m] = md;
                    gwr[m] = md ? dma_wr : cpu_wr;
                    e_en[m] = 1;
                    e_we[m] = gwr[m];
                    e_addr[m] = md ? dma_addr : cpu_addr;
                    e_wdata[m] = md ? dma_wdata : cpu_wdata;
                    if (gwr[m]) begin
                        gmem[m][e_addr[m]] = e_wdata[m];
                        gwrt[m][e_addr[m]] = 1'b1;
                    end else begin
                        exp_rd[m] = gwrt[m][e_addr[m]] ? gmem[m][e_addr[m]] : pat(e_addr[m]);
                    end
                end
            end
        end
    end

    int ack_log [2][$];
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (cpu_ack[m]) ack_log[m].push_back(0);
            if (dma_ack[m]) ack_log[m].push_back(1);
            check(m, "sram_en", {31'h0, sram_en[m]}, {31'h0, e_en[m]});
            check(m, "sram_we", {31'h0, sram_we[m]}, {31'h0, e_we[m]});
            check(m, "sram_addr", {22'h0, sram_addr[m]}, {22'h0, e_addr[m]});
            check(m, "sram_wdata", sram_wdata[m], e_wdata[m]);
            check(m, "cpu_ack", {31'h0, cpu_ack[m]}, {31'h0, e_cack[m]});
            check(m, "dma_ack", {31'h0, dma_ack[m]}, {31'h0, e_dack[m]});
            if (!e_cack[m]) check(m, "cpu_rdata_idle", cpu_rdata[m], 32'h0);
            else if (e_rdchk[m]) check(m, "cpu_rdata", cpu_rdata[m], exp_rd[m]);
            if (!e_dack[m]) check(m, "dma_rdata_idle", dma_rdata[m], 32'h0);
            else if (e_rdchk[m]) check(m, "dma_rdata", dma_rdata[m], exp_rd[m]);
            if (!cnt_forced) check(m, "conflict_cnt", {16'h0, conflict_cnt[m]}, {16'h0, mcnt[m]});
        end
    end

    task automatic do_req(input bit dma, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bit got;
        @(posedge clk); #2;
        if (dma) begin dma_sel = 1; dma_wr = wr; dma_addr = a; dma_wdata = wd; end
        else     begin cpu_sel = 1; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; end
        got = 0; rd = 32'h0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma ? dma_ack[1] : cpu_ack[1]) begin
                rd = dma ? dma_rdata[1] : cpu_rdata[1];
                lat = i;
                got = 1;
                break;
            end
        end
        check(-1, "req_ack_seen", {31'h0, got}, 32'h1);
        @(posedge clk); #2;
        if (dma) dma_sel = 0; else cpu_sel = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst = 1;
        @(posedge clk); #2 rst = 0;
    endtask

    int exp_prio [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_rr   [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        logic [31:0] rd;
        int lat, t1, t2, s0, s1;

        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check(-1, "rst_sram_en", {31'h0, sram_en[1]}, 32'h0);
        check(-1, "rst_sram_addr", {22'h0, sram_addr[1]}, 32'h0);
        check(-1, "rst_cpu_ack", {31'h0, cpu_ack[1]}, 32'h0);
        check(-1, "rst_dma_rdata", dma_rdata[0], 32'h0);
        check(-1, "rst_conflict", {16'h0, conflict_cnt[0]}, 32'h0);
        @(posedge clk); #2 rst = 0;

        do_req(0, 0, 10'h010, 32'h0, rd, lat);
        check(-1, "cpu_read_data", rd, 32'hDEADBEEF);
        check(-1, "cpu_read_latency", lat, 2);

        do_req(0, 1, 10'h155, 32'hAAAA5555, rd, lat);
        do_req(0, 0, 10'h155, 32'h0, rd, lat);
        check(-1, "cpu_readback", rd, 32'hAAAA5555);

        // DMA write then read with sel held across both accesses
        @(posedge clk); #2;
        dma_sel = 1; dma_wr = 1; dma_addr = 10'h3FF; dma_wdata = 32'h12345678;
        t1 = -1; t2 = -1; rd = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_ack[1]) begin t1 = k; break; end
        end
        dma_wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_ack[1]) begin t2 = k; rd = dma_rdata[1]; break; end
        end
        @(posedge clk); #2 dma_sel = 0;
        check(-1, "dma_readback", rd, 32'h12345678);
        check(-1, "dma_ack_spacing", t2 - t1, 3);

        // Both requesters held continuously from a fresh reset
        pulse_reset();
        s0 = ack_log[0].size();
        s1 = ack_log[1].size();
        @(posedge clk); #2;
        cpu_sel = 1; cpu_wr = 0; cpu_addr = 10'h020;
        dma_sel = 1; dma_wr = 0; dma_addr = 10'h030;
        repeat (30) @(posedge clk);
        #2;
        check(-1, "tie_conflict_rr", {16'h0, conflict_cnt[0]}, 32'd10);
        check(-1, "tie_conflict_prio", {16'h0, conflict_cnt[1]}, 32'd10);
        cpu_sel = 0; dma_sel = 0;
        check(-1, "tie_grants_rr", ack_log[0].size() - s0, 10);
        check(-1, "tie_grants_prio", ack_log[1].size() - s1, 10);
        for (int i = 0; i < 10; i++) begin
            if (ack_log[0].size() > s0 + i) check(-1, $sformatf("rr_order%0d", i), ack_log[0][s0 + i], exp_rr[i]);
            if (ack_log[1].size() > s1 + i) check(-1, $sformatf("prio_order%0d", i), ack_log[1][s1 + i], exp_prio[i]);
        end
        repeat (4) @(posedge clk);

        // Reset while the access strobe is out
        @(posedge clk); #2;
        cpu_sel = 1; cpu_wr = 0; cpu_addr = 10'h005;
        @(posedge clk); #2;
        check(-1, "pre_abort_en", {31'h0, sram_en[1]}, 32'h1);
        rst = 1; cpu_sel = 0;
        #1;
        check(-1, "abort_en", {31'h0, sram_en[1]}, 32'h0);
        check(-1, "abort_cpu_ack", {31'h0, cpu_ack[1]}, 32'h0);
        check(-1, "abort_dma_ack", {31'h0, dma_ack[0]}, 32'h0);
        @(posedge clk); #2 rst = 0;
        do_req(0, 0, 10'h010, 32'h0, rd, lat);
        check(-1, "post_abort_data", rd, 32'hDEADBEEF);
        check(-1, "post_abort_latency", lat, 2);
        repeat (3) @(posedge clk);

        // Counter saturation and clear priority
        @(posedge clk); #2;
        force u_rr.conflict_q = 16'hFFFE;
        force u_prio.conflict_q = 16'hFFFE;
        preload_req = 1; cnt_forced = 1;
        @(posedge clk); #1;
        release u_rr.conflict_q;
        release u_prio.conflict_q;
        preload_req = 0; cnt_forced = 0;
        #1;
        cpu_sel = 1; cpu_wr = 0; cpu_addr = 10'h040;
        dma_sel = 1; dma_wr = 0; dma_addr = 10'h041;
        repeat (6) @(posedge clk);
        #2;
        check(-1, "sat_rr", {16'h0, conflict_cnt[0]}, 32'h0000FFFF);
        check(-1, "sat_prio", {16'h0, conflict_cnt[1]}, 32'h0000FFFF);
        stat_clr = 1;
        @(posedge clk); #2;
        stat_clr = 0; cpu_sel = 0; dma_sel = 0;
        check(-1, "clr_rr", {16'h0, conflict_cnt[0]}, 32'h0);
        check(-1, "clr_prio", {16'h0, conflict_cnt[1]}, 32'h0);
        repeat (6) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
